pulse_period_meter: RTL and testbench

//   Receive end of the timer tick interface. Takes a pulse train, such as the
//   one-clock ticks from the periodic timer or an external pin, synchronises it
//   and detects rising edges. Measures the clk_i cycle count between successive

---
 rtl/pulse_period_meter_if.sv | 15 +
 rtl/pulse_period_meter.sv | 110 +++++++++++
 tb/tb_pulse_period_meter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_period_meter_if.sv
// Bundle of the pulse input and measurement outputs of pulse_period_meter.
// The slave modport is the meter itself; the master side feeds pulses and observes results.
`timescale 1ns/1ps
interface pulse_period_meter_if #(
    parameter int unsigned W = 24
);
    logic         pulse_i;
    logic [W-1:0] period_o;
    logic         valid_o;
    logic         timeout_o;
    logic         locked_o;

    modport master (output pulse_i, input period_o, valid_o, timeout_o, locked_o);
    modport slave  (input pulse_i, output period_o, valid_o, timeout_o, locked_o);
endinterface

// File: rtl/pulse_period_meter.sv
// Measures the clk_i cycle count between successive rising edges of a possibly
// asynchronous pulse train and publishes each period with a one-cycle strobe.
`timescale 1ns/1ps
module pulse_period_meter #(
    parameter int unsigned  W          = 24,
    parameter logic [W-1:0] TIMEOUT    = {W{1'b1}},
    parameter logic [W-1:0] MIN_PERIOD = W'(2)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    pulse_period_meter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic         sync1_q, sync2_q, prev_q;
    logic         edge_s;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    logic         locked_q, locked_d;

    // Two-flop synchroniser followed by a history flop for rising-edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.pulse_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_s = sync2_q & ~prev_q;

    // Measurement state, counter and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    // Next-state logic; an edge coinciding with the timeout count is still a measurement
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        locked_d  = locked_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    cnt_d   = W'(1);
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (edge_s && (cnt_q >= MIN_PERIOD)) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    cnt_d     = W'(1);
                    locked_d  = 1'b1;
                    timeout_d = 1'b0;
                end else if (edge_s) begin
                    cnt_d = cnt_q + W'(1);
                end else if (cnt_q == TIMEOUT) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.period_o  = period_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = timeout_q;
    assign bus.locked_o  = locked_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: four instances cover default, short
// timeout, raised glitch threshold and edge-at-timeout configurations.
`timescale 1ns/1ps
module tb_pulse_period_meter;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    pulse_period_meter_if #(.W(24)) if0 ();
    pulse_period_meter_if #(.W(8))  if1 ();
    pulse_period_meter_if #(.W(16)) if2 ();
    pulse_period_meter_if #(.W(8))  if3 ();

    pulse_period_meter #(.W(24)) u0 (.clk_i(clk), .rstn_i(rstn), .bus(if0));
    pulse_period_meter #(.W(8), .TIMEOUT(8'd100)) u1 (.clk_i(clk), .rstn_i(rstn), .bus(if1));
    pulse_period_meter #(.W(16), .MIN_PERIOD(16'd4)) u2 (.clk_i(clk), .rstn_i(rstn), .bus(if2));
    pulse_period_meter #(.W(8), .TIMEOUT(8'd50)) u3 (.clk_i(clk), .rstn_i(rstn), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor on u0 for the asynchronous-input run
    logic        mon_en;
    int          mon_cnt;
    logic [31:0] mon_min;
    logic [31:0] mon_max;
    logic        mon_dup;
    logic        mon_prev;

    always @(negedge clk) begin
        if (!mon_en) begin
            mon_cnt  <= 0;
            mon_min  <= 32'hFFFF_FFFF;
            mon_max  <= 32'd0;
            mon_dup  <= 1'b0;
            mon_prev <= 1'b0;
        end else begin
            if (if0.valid_o) begin
                mon_cnt <= mon_cnt + 1;
                if (32'(if0.period_o) < mon_min) mon_min <= 32'(if0.period_o);
                if (32'(if0.period_o) > mon_max) mon_max <= 32'(if0.period_o);
                if (mon_prev) mon_dup <= 1'b1;
            end
            mon_prev <= if0.valid_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pulse(input int idx, input logic v);
        case (idx)
            0:       if0.pulse_i = v;
            1:       if1.pulse_i = v;
            2:       if2.pulse_i = v;
            default: if3.pulse_i = v;
        endcase
    endtask

    // One-clock pulse; returns just after the edge that the meter acts on
    task automatic fire(input int idx);
        set_pulse(idx, 1'b1);
        tick(1);
        set_pulse(idx, 1'b0);
        tick(2);
    endtask

    initial begin
        int unsigned gap;
        int unsigned wid;
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rstn        = 1'b0;
        if0.pulse_i = 1'b0;
        if1.pulse_i = 1'b0;
        if2.pulse_i = 1'b0;
        if3.pulse_i = 1'b0;

        // Reset state
        tick(2);
        chk("rst_period", 32'(if0.period_o), 32'd0);
        chk("rst_valid", 32'(if0.valid_o), 32'd0);
        chk("rst_timeout", 32'(if0.timeout_o), 32'd0);
        chk("rst_locked", 32'(if0.locked_o), 32'd0);
        chk("rst_u1_period", 32'(if1.period_o), 32'd0);
        rstn = 1'b1;
        tick(2);

        // Test 1: regular 1-clk pulses, first edge only arms
        fire(0);
        chk("t1_first_valid", 32'(if0.valid_o), 32'd0);
        chk("t1_first_locked", 32'(if0.locked_o), 32'd0);
        tick(598);
        fire(0);
        chk("t1_valid", 32'(if0.valid_o), 32'd1);
        chk("t1_period", 32'(if0.period_o), 32'd601);
        chk("t1_locked", 32'(if0.locked_o), 32'd1);
        tick(1);
        chk("t1_valid_one_cycle", 32'(if0.valid_o), 32'd0);
        chk("t1_period_hold", 32'(if0.period_o), 32'd601);
        tick(597);
        fire(0);
        chk("t1_valid2", 32'(if0.valid_o), 32'd1);
        chk("t1_period2", 32'(if0.period_o), 32'd601);
        // Back-to-back pulses at the MIN_PERIOD boundary of 2
        tick(47);
        set_pulse(0, 1'b1);
        tick(1);
        set_pulse(0, 1'b0);
        tick(1);
        set_pulse(0, 1'b1);
        tick(1);
        set_pulse(0, 1'b0);
        chk("t1_p50_valid", 32'(if0.valid_o), 32'd1);
        chk("t1_p50_period", 32'(if0.period_o), 32'd50);
        tick(1);
        chk("t1_no_consecutive_valid", 32'(if0.valid_o), 32'd0);
        tick(1);
        chk("t1_p2_valid", 32'(if0.valid_o), 32'd1);
        chk("t1_p2_period", 32'(if0.period_o), 32'd2);

        // Test 2: timeout after 100 silent cycles, re-arm, then measure 37
        fire(1);
        chk("t2_arm_valid", 32'(if1.valid_o), 32'd0);
        tick(27);
        fire(1);
        chk("t2_p30_period", 32'(if1.period_o), 32'd30);
        chk("t2_p30_locked", 32'(if1.locked_o), 32'd1);
        tick(99);
        chk("t2_pre_timeout", 32'(if1.timeout_o), 32'd0);
        chk("t2_pre_locked", 32'(if1.locked_o), 32'd1);
        tick(1);
        chk("t2_timeout", 32'(if1.timeout_o), 32'd1);
        chk("t2_timeout_locked", 32'(if1.locked_o), 32'd0);
        chk("t2_timeout_period_kept", 32'(if1.period_o), 32'd30);
        fire(1);
        chk("t2_rearm_valid", 32'(if1.valid_o), 32'd0);
        chk("t2_rearm_timeout_kept", 32'(if1.timeout_o), 32'd1);
        tick(34);
        fire(1);
        chk("t2_p37_valid", 32'(if1.valid_o), 32'd1);
        chk("t2_p37_period", 32'(if1.period_o), 32'd37);
        chk("t2_p37_timeout", 32'(if1.timeout_o), 32'd0);
        chk("t2_p37_locked", 32'(if1.locked_o), 32'd1);

        // Test 3: MIN_PERIOD=4, edges at t, t+2, t+10, t+14
        set_pulse(2, 1'b1);
        tick(1);
        set_pulse(2, 1'b0);
        tick(1);
        set_pulse(2, 1'b1);
        tick(1);
        set_pulse(2, 1'b0);
        tick(2);
        chk("t3_glitch_ignored", 32'(if2.valid_o), 32'd0);
        tick(5);
        fire(2);
        chk("t3_p10_valid", 32'(if2.valid_o), 32'd1);
        chk("t3_p10_period", 32'(if2.period_o), 32'd10);
        tick(1);
        fire(2);
        chk("t3_p4_valid", 32'(if2.valid_o), 32'd1);
        chk("t3_p4_period", 32'(if2.period_o), 32'd4);

        // Test 4: edge exactly at counter==TIMEOUT wins over the timeout
        fire(3);
        tick(47);
        fire(3);
        chk("t4_valid", 32'(if3.valid_o), 32'd1);
        chk("t4_period", 32'(if3.period_o), 32'd50);
        chk("t4_timeout", 32'(if3.timeout_o), 32'd0);
        chk("t4_locked", 32'(if3.locked_o), 32'd1);

        // Test 5: asynchronous reset in the middle of a period
        tick(10);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_period", 32'(if0.period_o), 32'd0);
        chk("t5_rst_locked", 32'(if0.locked_o), 32'd0);
        chk("t5_rst_valid", 32'(if0.valid_o), 32'd0);
        tick(1);
        rstn = 1'b1;
        tick(2);
        fire(0);
        chk("t5_arm_valid", 32'(if0.valid_o), 32'd0);
        tick(17);
        fire(0);
        chk("t5_valid", 32'(if0.valid_o), 32'd1);
        chk("t5_period", 32'(if0.period_o), 32'd20);

        // Test 6: asynchronous pulses, random phase, period 1000 +/- 1 clk
        #($urandom_range(9, 1));
        for (int i = 0; i < 9; i++) begin
            if (i == 1) mon_en = 1'b1;
            gap = 32'd9990 + $urandom_range(20);
            wid = 32'd20 + $urandom_range(10);
            if0.pulse_i = 1'b1;
            #(wid);
            if0.pulse_i = 1'b0;
            #(gap - wid);
        end
        tick(5);
        chk("t6_valid_count", 32'(mon_cnt), 32'd8);
        chk("t6_period_min_ge_999", 32'(mon_min >= 32'd999), 32'd1);
        chk("t6_period_max_le_1001", 32'(mon_max <= 32'd1001), 32'd1);
        chk("t6_no_duplicate_valid", 32'(mon_dup), 32'd0);
        chk("t6_locked", 32'(if0.locked_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
